// File: rtl/chan_downselect.sv
// Bin down-selector: forwards mask-enabled FFT bins and repacketizes them with tlast.
// Optional statistics counters (drop_cnt, frame_cnt) are built when CHAN_DS_STATS_EN is defined.
module chan_downselect #(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_WIDTH  = 11,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  sync_reset,
    input  logic [BIN_WIDTH:0]    fft_size,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [BIN_WIDTH-1:0]  s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [31:0]           s_axis_select_tdata,
    input  logic                  s_axis_select_tlast,
    input  logic                  s_axis_select_tvalid,
    output logic                  s_axis_select_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [BIN_WIDTH-1:0]  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
`ifdef CHAN_DS_STATS_EN
    ,
    output logic [31:0]           drop_cnt,
    output logic [31:0]           frame_cnt
`endif
);

    localparam int MASK_BITS = 1 << BIN_WIDTH;
    localparam int PTR_W     = BIN_WIDTH - 5;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Ready never depends combinationally on the same interface's valid or on m_axis_tready.

    logic [MASK_BITS-1:0]  active_q, active_d;
    logic [MASK_BITS-1:0]  shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [BIN_WIDTH-1:0]  buf_user_q [2];
    logic [BIN_WIDTH-1:0]  buf_user_d [2];
    logic [1:0]            buf_last_q, buf_last_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  in_fire, sel_fire, out_fire;
    logic                  in_range, swap, mask_bit, fwd;
    logic [PTR_W:0]        word_lim, ptr_inc;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic [LEN_WIDTH:0]    cnt_inc;
    logic                  is_last;

    assign in_fire   = s_axis_tvalid & s_axis_tready;
    assign sel_fire  = s_axis_select_tvalid & s_axis_select_tready;
    assign out_fire  = m_axis_tvalid & m_axis_tready;
    assign in_range  = ({1'b0, s_axis_tuser} < fft_size);
    assign swap      = in_fire & pending_q & (s_axis_tuser == '0);
    // The bin-0 beat that triggers the swap is already judged by the new mask.
    assign mask_bit  = swap ? shadow_q[s_axis_tuser] : active_q[s_axis_tuser];
    assign fwd       = in_fire & in_range & mask_bit;

    assign s_axis_tready        = (count_q != 2'd2);
    assign s_axis_select_tready = ~pending_q;
    assign m_axis_tvalid        = (count_q != 2'd0);
    assign m_axis_tdata         = buf_data_q[rd_ptr_q];
    assign m_axis_tuser         = buf_user_q[rd_ptr_q];
    assign m_axis_tlast         = buf_last_q[rd_ptr_q];

    always_comb begin
        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        ptr_d      = ptr_q;
        pkt_cnt_d  = pkt_cnt_q;
        len_d      = len_q;
        buf_data_d = buf_data_q;
        buf_user_d = buf_user_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        // Mask words per frame: N/32, but at least one word for small FFTs.
        word_lim = (fft_size[BIN_WIDTH:5] == '0) ? {{PTR_W{1'b0}}, 1'b1} : fft_size[BIN_WIDTH:5];
        ptr_inc  = {1'b0, ptr_q} + {{PTR_W{1'b0}}, 1'b1};

        if (sel_fire) begin
            shadow_d[{ptr_q, 5'd0} +: 32] = s_axis_select_tdata;
            ptr_d = (ptr_inc >= word_lim) ? '0 : ptr_inc[PTR_W-1:0];
            if (s_axis_select_tlast) begin
                pending_d = 1'b1;
                ptr_d     = '0;
            end
        end

        if (swap) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        // Packet length is captured when the first sample of a packet is forwarded.
        if (pkt_cnt_q == '0) begin
            cur_len = (pkt_len == '0) ? {{(LEN_WIDTH-1){1'b0}}, 1'b1} : pkt_len;
        end else begin
            cur_len = len_q;
        end
        cnt_inc = {1'b0, pkt_cnt_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
        is_last = (cnt_inc == {1'b0, cur_len});

        if (fwd) begin
            len_d                = cur_len;
            pkt_cnt_d            = is_last ? '0 : cnt_inc[LEN_WIDTH-1:0];
            buf_data_d[wr_ptr_q] = s_axis_tdata;
            buf_user_d[wr_ptr_q] = s_axis_tuser;
            buf_last_d[wr_ptr_q] = is_last;
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (out_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({fwd, out_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            active_q   <= '1;
            shadow_q   <= '1;
            pending_q  <= 1'b0;
            ptr_q      <= '0;
            pkt_cnt_q  <= '0;
            len_q      <= '0;
            buf_data_q <= '{default: '0};
            buf_user_q <= '{default: '0};
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            len_q      <= len_d;
            buf_data_q <= buf_data_d;
            buf_user_q <= buf_user_d;
            buf_last_q <= buf_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef CHAN_DS_STATS_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (in_fire && !fwd) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
        if (in_fire && (s_axis_tuser == '0)) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_chan_downselect.sv
// Testbench for chan_downselect: random and directed stimulus against a transaction-level
// model of the mask/packet rules; a negedge monitor pops expected beats from a queue.
module tb_chan_downselect;

    localparam int DW = 32;
    localparam int BW = 11;
    localparam int LW = 16;
    localparam int EW = DW + BW + 1;

    logic          clk;
    logic          sync_reset;
    logic [BW:0]   fft_size;
    logic [LW-1:0] pkt_len;
    logic [DW-1:0] s_axis_tdata;
    logic [BW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [31:0]   s_axis_select_tdata;
    logic          s_axis_select_tlast;
    logic          s_axis_select_tvalid;
    logic          s_axis_select_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [BW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
`ifdef CHAN_DS_STATS_EN
    logic [31:0]   drop_cnt;
    logic [31:0]   frame_cnt;
`endif

    chan_downselect #(.DATA_WIDTH(DW), .BIN_WIDTH(BW), .LEN_WIDTH(LW)) dut (
        .clk                  (clk),
        .sync_reset           (sync_reset),
        .fft_size             (fft_size),
        .pkt_len              (pkt_len),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tuser         (s_axis_tuser),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .s_axis_select_tdata  (s_axis_select_tdata),
        .s_axis_select_tlast  (s_axis_select_tlast),
        .s_axis_select_tvalid (s_axis_select_tvalid),
        .s_axis_select_tready (s_axis_select_tready),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tuser         (m_axis_tuser),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready)
`ifdef CHAN_DS_STATS_EN
        ,
        .drop_cnt             (drop_cnt),
        .frame_cnt            (frame_cnt)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int out_count = 0;
    bit bp_en = 1'b0;
    logic [EW-1:0] exp_q[$];

    // Reference model state
    bit act_m [2048];
    bit shad_m [2048];
    bit pend_m;
    int ptr_m, pcnt_m, plen_m, drops_m, frames_m;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (act_m[i]) begin
            act_m[i]  = 1'b1;
            shad_m[i] = 1'b1;
        end
        pend_m = 1'b0; ptr_m = 0; pcnt_m = 0; plen_m = 1; drops_m = 0; frames_m = 0;
        exp_q.delete();
    endtask

    task automatic model_sel(input logic [31:0] w, input logic last);
        int words;
        for (int b = 0; b < 32; b++) shad_m[ptr_m * 32 + b] = w[b];
        words = int'(fft_size) / 32;
        if (words < 1) words = 1;
        ptr_m = (ptr_m + 1 >= words) ? 0 : ptr_m + 1;
        if (last) begin
            pend_m = 1'b1;
            ptr_m  = 0;
        end
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input int u);
        bit sel;
        bit last;
        logic [BW-1:0] ub;
        if (pend_m && u == 0) begin
            act_m  = shad_m;
            pend_m = 1'b0;
        end
        if (u == 0) frames_m++;
        sel = (u < int'(fft_size)) && act_m[u];
        if (!sel) begin
            drops_m++;
            return;
        end
        if (pcnt_m == 0) plen_m = (pkt_len == 0) ? 1 : int'(pkt_len);
        pcnt_m++;
        last = (pcnt_m == plen_m);
        if (last) pcnt_m = 0;
        ub = u[BW-1:0];
        exp_q.push_back({d, ub, last});
    endtask

    // Model: observes handshakes mid-cycle; each one completes at the next rising edge.
    always @(negedge clk) begin
        if (sync_reset) begin
            model_reset();
        end else begin
            if (s_axis_tvalid && s_axis_tready) model_beat(s_axis_tdata, int'(s_axis_tuser));
            if (s_axis_select_tvalid && s_axis_select_tready)
                model_sel(s_axis_select_tdata, s_axis_select_tlast);
        end
    end

    // Scoreboard monitor with output-hold check
    bit prev_stall = 1'b0;
    logic [EW-1:0] prev_beat;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (sync_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check("hold_beat", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(prev_beat));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got beat 0x%0h, expected no output",
                             {m_axis_tdata, m_axis_tuser, m_axis_tlast});
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 64'(e));
                end
                out_count++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    // Output backpressure driver
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Driver tasks (called #1 after a rising edge, return #1 after the accepting edge)
    task automatic send_beat(input logic [DW-1:0] d, input int u);
        int  guard = 0;
        bit  acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tuser  = u[BW-1:0];
        s_axis_tvalid = 1'b1;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no s_axis_tready in %0d cycles, expected accept", guard);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_sel(input logic [31:0] w, input logic last);
        int  guard = 0;
        bit  acc = 1'b0;
        s_axis_select_tdata  = w;
        s_axis_select_tlast  = last;
        s_axis_select_tvalid = 1'b1;
        while (!acc && guard < 500) begin
            @(negedge clk);
            acc = s_axis_select_tready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL sel_timeout: got no select_tready in %0d cycles, expected accept", guard);
        end
        s_axis_select_tvalid = 1'b0;
        s_axis_select_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int first, input int last_bin);
        for (int b = first; b <= last_bin; b++) send_beat($urandom, b);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && g < 4000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int c0;
        sync_reset = 1'b1;
        fft_size = 12'd8;
        pkt_len = 16'd4;
        s_axis_tdata = '0;
        s_axis_tuser = '0;
        s_axis_tvalid = 1'b0;
        s_axis_select_tdata = '0;
        s_axis_select_tlast = 1'b0;
        s_axis_select_tvalid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        sync_reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd1);
        check("rst_sel_tready", 64'(s_axis_select_tready), 64'd1);
`ifdef CHAN_DS_STATS_EN
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;

        // 1: default mask, two frames of 8, packets of 4
        c0 = out_count;
        send_frame(0, 7);
        send_frame(0, 7);
        drain();
        check("t1_out_count", 64'(out_count - c0), 64'd16);

        // 2: mask 0x5 keeps bins 0 and 2
        c0 = out_count;
        send_sel(32'h0000_0005, 1'b1);
        repeat (3) send_frame(0, 7);
        drain();
        check("t2_out_count", 64'(out_count - c0), 64'd6);

        // 3: load mid-frame, switch at the next bin 0
        c0 = out_count;
        send_frame(0, 4);
        send_sel(32'h0000_00E0, 1'b1);
        @(negedge clk);
        check("t3_sel_tready_pending", 64'(s_axis_select_tready), 64'd0);
        @(posedge clk);
        #1;
        send_frame(5, 7);
        @(negedge clk);
        check("t3_sel_tready_still_pending", 64'(s_axis_select_tready), 64'd0);
        @(posedge clk);
        #1;
        send_beat($urandom, 0);
        @(negedge clk);
        check("t3_sel_tready_after_swap", 64'(s_axis_select_tready), 64'd1);
        @(posedge clk);
        #1;
        send_frame(1, 7);
        drain();
        check("t3_out_count", 64'(out_count - c0), 64'd5);

        // 3b: select tlast and bin 0 in the same cycle: swap waits a frame
        c0 = out_count;
        fork
            send_sel(32'h0000_0001, 1'b1);
            send_beat($urandom, 0);
        join
        @(negedge clk);
        check("t3b_sel_tready_pending", 64'(s_axis_select_tready), 64'd0);
        @(posedge clk);
        #1;
        send_frame(1, 7);
        send_frame(0, 7);
        drain();
        check("t3b_out_count", 64'(out_count - c0), 64'd4);

        // 4: N=2048, word 63 selects bin 2047, extra word 64 overwrites word 0
        fft_size = 12'd2048;
        pkt_len = 16'd3;
        c0 = out_count;
        for (int w = 0; w < 64; w++)
            send_sel((w == 63) ? 32'h8000_0000 : ((w == 0) ? 32'hFFFF_FFFF : 32'h0), 1'b0);
        send_sel(32'h0, 1'b1);
        send_frame(0, 2047);
        drain();
        check("t4_out_count", 64'(out_count - c0), 64'd1);

        // 5: random traffic with 50% output backpressure
        fft_size = 12'd64;
        pkt_len = 16'd5;
        send_sel($urandom, 1'b0);
        send_sel($urandom, 1'b1);
        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 49) == 0) pkt_len = 16'($urandom_range(0, 7));
            if (i == 500) begin
                send_sel($urandom, 1'b0);
                send_sel($urandom, 1'b1);
            end
            send_beat($urandom, $urandom_range(0, 79));
        end
        drain();
        bp_en = 1'b0;

        // 6: reset mid-packet, then resume with the all-ones mask
        fft_size = 12'd8;
        pkt_len = 16'd4;
        send_sel(32'h0000_0002, 1'b1);
        send_frame(0, 5);
        do_reset();
        @(negedge clk);
        check("t6_m_tvalid_after_reset", 64'(m_axis_tvalid), 64'd0);
        check("t6_m_tlast_after_reset", 64'(m_axis_tlast), 64'd0);
        check("t6_sel_tready_after_reset", 64'(s_axis_select_tready), 64'd1);
`ifdef CHAN_DS_STATS_EN
        check("t6_drop_cnt_after_reset", 64'(drop_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        c0 = out_count;
        send_frame(0, 7);
        drain();
        check("t6_out_count", 64'(out_count - c0), 64'd8);
        send_sel(32'h0000_0005, 1'b1);
        send_frame(0, 7);
        send_frame(0, 7);
        drain();
`ifdef CHAN_DS_STATS_EN
        @(negedge clk);
        check("t6_drop_cnt", 64'(drop_cnt), 64'd12);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd3);
        @(posedge clk);
        #1;
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
